phy_tx_symbol_gen: RTL and testbench
====================================

Name: phy_tx_symbol_gen

Overview:
- clk_4f byte-level symbol generator feeding the PHY TX parallel-to-serial stage.
- After reset it emits a comma (0xBC) training burst, then forwards payload bytes under a valid/ready handshake.
- Emits the idle symbol (0x7C) whenever no payload byte is accepted.
- Its output stream is exactly what the downstream serializer/receiver pair uses to declare the link active (4 consecutive 0xBC) and to flag idle (0x7C).

Parameters:
- DATA_W, 8, symbol/payload width in bits.
- COM_SYM, 8'hBC, comma symbol used for training and skip insertion.
- IDLE_SYM, 8'h7C, symbol sent when active with no accepted payload.
- TRAIN_COMMAS, 4, number of clock edges after reset release spent in TRAIN emitting COM_SYM; legal range 1..255.
- SKIP_PERIOD, 16, ACTIVE-cycle period of comma insertion; used only with PHY_TX_SKIP_EN; legal range 2..255.

Ports:
- clk_4f  in  1  byte clock.
- reset  in  1  synchronous, active-low reset.
- data_in  in  DATA_W  payload byte.
- valid_in  in  1  data_in holds a valid byte.
- ready_out  out  1  block accepts data_in on this edge; combinational from registered state only.
- sym_out  out  DATA_W  registered symbol to the serializer.
- sym_is_data  out  1  registered; sym_out carries an accepted payload byte.
- link_state  out  2  registered; 2'b01 TRAIN, 2'b10 ACTIVE (2'b00, 2'b11 unused).

Behaviour:
- Reset and clocking: reset, synchronous, active-low; clock clk_4f.
- Reset values (on any edge with reset==0): state=TRAIN, train_cnt=0, skip_cnt=0, sym_out=COM_SYM, sym_is_data=0, link_state=2'b01.
- Inputs are ignored while reset is low.
- FSM has two states: TRAIN and ACTIVE.
- TRAIN, per edge:
  - sym_out<=COM_SYM, sym_is_data<=0, train_cnt<=train_cnt+1.
  - If train_cnt==TRAIN_COMMAS-1: state<=ACTIVE and link_state<=2'b10; train_cnt holds at its final value.
- ready_out=0 in TRAIN.
- Training timing: COM_SYM is on sym_out continuously from reset through the TRAIN_COMMAS-th edge after release, so the downstream sees at least TRAIN_COMMAS+1 consecutive commas. ready_out rises right after the TRAIN_COMMAS-th edge.
- ACTIVE:
  - ready_out=1, except in a skip cycle (see Optional Feature).
  - On an edge with valid_in&&ready_out: sym_out<=data_in, sym_is_data<=1.
  - Otherwise: sym_out<=IDLE_SYM, sym_is_data<=0.
- Latency: an accepted byte appears on sym_out exactly 1 edge after acceptance. There is no buffering; a byte not accepted stays the source's responsibility, and the source must hold data_in/valid_in stable until accepted.
- Payload bytes equal to COM_SYM or IDLE_SYM are forwarded unchanged with sym_is_data=1; they are not escaped.
- ACTIVE is left only through reset.
- Reset mid-operation: the next edge with reset==0 restores all reset values, and ready_out drops combinationally after that edge. Any byte presented on that edge is dropped, and training restarts in full.
- Counter widths: train_cnt and skip_cnt are 8 bits and never wrap in normal operation.

Optional Feature:
- Macro: PHY_TX_SKIP_EN.
- With the macro, in ACTIVE:
  - skip_cnt increments every edge and wraps SKIP_PERIOD-1 -> 0.
  - While skip_cnt==SKIP_PERIOD-1: ready_out=0, and that edge emits sym_out=COM_SYM, sym_is_data=0.
  - valid_in held across the skip cycle is accepted on the next edge with no loss.
  - skip_cnt starts at 0 on the TRAIN->ACTIVE edge.
- Without the macro: skip_cnt logic is absent, ACTIVE never emits COM_SYM, and ready_out is constant 1 in ACTIVE.

Decomposition:
- Shared package phy_tx_pkg holds:
  - COM_SYM=8'hBC and IDLE_SYM=8'h7C.
  - The state encoding TRAIN=2'b01, ACTIVE=2'b10, which link_state reuses.
  - DATA_W.
- The downstream serializer and receiver import the same symbol constants.
- One natural sub-module: phy_tx_skip_timer, covering skip_cnt and the skip-cycle flag, instantiated only under PHY_TX_SKIP_EN.

Test Plan:
- Reset low for 3 edges, then release with valid_in=0: sym_out=0xBC through edge 4 after release, link_state 01->10 at edge 4, ready_out=1 after edge 4, sym_out=0x7C from edge 5 onward.
- Burst after training: valid_in=1 with 0x11,0x22,0x33 on consecutive edges -> sym_out=0x11,0x22,0x33 with sym_is_data=1 one edge later each; valid_in=0 after that -> 0x7C with sym_is_data=0.
- Payload 0xBC and 0x7C in ACTIVE -> forwarded unchanged with sym_is_data=1; link_state stays 2'b10.
- Reset asserted mid-burst while valid_in=1 and data_in=0x55: next edge sym_out=0xBC, ready_out=0, link_state=01, 0x55 never appears; a full 4-edge retrain follows.
- PHY_TX_SKIP_EN, SKIP_PERIOD=16, continuous valid_in with incrementing data: every 16th ACTIVE edge emits 0xBC with sym_is_data=0; ready_out=0 in that cycle; the held byte is sent on the following edge with no gaps or duplicates.
- Without PHY_TX_SKIP_EN, same stimulus for 64 ACTIVE edges: no 0xBC symbol emitted and ready_out never deasserts.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_pkg
// Shared constants for the PHY TX path. The symbol generator, the serializer and
// the receiver all import these, so the comma and idle codes are defined here
// only once.
//   DATA_W       : symbol / payload width in bits
//   COM_SYM      : comma symbol, used for the training burst and skip insertion
//   IDLE_SYM     : idle symbol, sent when the link is active and no byte is taken
//   link_state_t : generator state encoding, also driven out on link_state
// -----------------------------------------------------------------------------
package phy_tx_pkg;

   localparam int         DATA_W   = 8;
   localparam logic [7:0] COM_SYM  = 8'hBC;
   localparam logic [7:0] IDLE_SYM = 8'h7C;

   // link_state reuses this encoding directly. 2'b00 and 2'b11 are never used.
   typedef enum logic [1:0] {
      ST_TRAIN  = 2'b01,
      ST_ACTIVE = 2'b10
   } link_state_t;

endpackage

// File: rtl/phy_tx_skip_timer.sv
// -----------------------------------------------------------------------------
// phy_tx_skip_timer
// Sets the pace for periodic comma (skip) insertion while the link is ACTIVE.
// The count holds at 0 outside ACTIVE, so it always starts from 0 on the edge
// where the link enters ACTIVE. While ACTIVE it counts every edge and wraps from
// SKIP_PERIOD-1 back to 0. The skip flag is high for the cycle in which the
// count equals SKIP_PERIOD-1.
// Ports:
//   clk_4f   in  byte clock
//   reset    in  synchronous, active-low reset
//   i_active in  generator is in ACTIVE
//   o_skip   out current cycle is a skip cycle (combinational from the count)
// -----------------------------------------------------------------------------
module phy_tx_skip_timer
#(
   parameter int SKIP_PERIOD = 16
)
(
   input  logic clk_4f,
   input  logic reset,
   input  logic i_active,
   output logic o_skip
);

   localparam logic [7:0] SKIP_LAST = 8'(SKIP_PERIOD - 1);

   logic [7:0] r_skip_cnt;
   logic       w_last;

   assign w_last = (r_skip_cnt == SKIP_LAST);
   assign o_skip = i_active && w_last;

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         r_skip_cnt <= 8'd0;
      end else if (i_active) begin
         r_skip_cnt <= w_last ? 8'd0 : r_skip_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/phy_tx_symbol_gen.sv
// -----------------------------------------------------------------------------
// phy_tx_symbol_gen
// Byte-level symbol generator that feeds the PHY TX serializer. After reset it
// sends a comma training burst. It then forwards payload bytes under a
// valid/ready handshake and sends IDLE_SYM in every cycle where no byte is
// accepted.
// Optional build macro: PHY_TX_SKIP_EN. When defined, a comma replaces one
// ACTIVE cycle in every SKIP_PERIOD cycles, and ready_out is low during that
// cycle.
// Ports:
//   clk_4f      in   byte clock
//   reset       in   synchronous, active-low reset
//   data_in     in   payload byte
//   valid_in    in   data_in holds a valid byte
//   ready_out   out  byte accepted on this edge (decoded from registered state only)
//   sym_out     out  registered symbol to the serializer
//   sym_is_data out  registered; sym_out carries an accepted payload byte
//   link_state  out  registered; 2'b01 TRAIN, 2'b10 ACTIVE
// -----------------------------------------------------------------------------
module phy_tx_symbol_gen
#(
   parameter int                DATA_W       = phy_tx_pkg::DATA_W,
   parameter logic [DATA_W-1:0] COM_SYM      = DATA_W'(phy_tx_pkg::COM_SYM),
   parameter logic [DATA_W-1:0] IDLE_SYM     = DATA_W'(phy_tx_pkg::IDLE_SYM),
   parameter int                TRAIN_COMMAS = 4,
   parameter int                SKIP_PERIOD  = 16
)
(
   input  logic              clk_4f,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] sym_out,
   output logic              sym_is_data,
   output logic [1:0]        link_state
);

   import phy_tx_pkg::*;

   // Reject illegal parameter values when the design is elaborated.
   if (TRAIN_COMMAS < 1 || TRAIN_COMMAS > 255) begin : g_bad_train_commas
      $error("phy_tx_symbol_gen: TRAIN_COMMAS must be in 1..255");
   end
   if (SKIP_PERIOD < 2 || SKIP_PERIOD > 255) begin : g_bad_skip_period
      $error("phy_tx_symbol_gen: SKIP_PERIOD must be in 2..255");
   end

   localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_COMMAS - 1);

   link_state_t       r_state;
   logic [7:0]        r_train_cnt;
   logic [DATA_W-1:0] r_sym;
   logic              r_is_data;

   logic w_active;
   logic w_skip;
   logic w_accept;

   assign w_active = (r_state == ST_ACTIVE);

`ifdef PHY_TX_SKIP_EN
   phy_tx_skip_timer #(
      .SKIP_PERIOD (SKIP_PERIOD)
   ) u_skip_timer (
      .clk_4f   (clk_4f),
      .reset    (reset),
      .i_active (w_active),
      .o_skip   (w_skip)
   );
`else
   assign w_skip = 1'b0;
`endif

   // ready_out is decoded from registered state only. During a skip cycle the
   // source keeps its byte, and the byte is taken on the next edge.
   assign ready_out = w_active && !w_skip;
   assign w_accept  = valid_in && ready_out;

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         r_state     <= ST_TRAIN;
         r_train_cnt <= 8'd0;
         r_sym       <= COM_SYM;
         r_is_data   <= 1'b0;
      end else begin
         case (r_state)
            ST_TRAIN: begin
               r_sym       <= COM_SYM;
               r_is_data   <= 1'b0;
               r_train_cnt <= r_train_cnt + 8'd1;
               if (r_train_cnt == TRAIN_LAST) begin
                  r_state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // ACTIVE is left only through reset. train_cnt keeps its final value.
               if (w_accept) begin
                  r_sym     <= data_in;
                  r_is_data <= 1'b1;
               end else if (w_skip) begin
                  r_sym     <= COM_SYM;
                  r_is_data <= 1'b0;
               end else begin
                  r_sym     <= IDLE_SYM;
                  r_is_data <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_TRAIN;
            end
         endcase
      end
   end

   assign sym_out     = r_sym;
   assign sym_is_data = r_is_data;
   assign link_state  = r_state;

endmodule

// File: tb/tb_phy_tx_symbol_gen.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_symbol_gen
// Directed bench for phy_tx_symbol_gen (TRAIN_COMMAS=4, SKIP_PERIOD=16).
// A behavioural model counts the edges since reset release and predicts every
// output from that count. A compare process checks the outputs against the model
// on each falling edge. The directed sequence also checks literal values at its
// key points. Set PHY_TX_SKIP_EN to run the skip-insertion build.
// -----------------------------------------------------------------------------
module tb_phy_tx_symbol_gen;

   localparam int TC = 4;
   localparam int SP = 16;
   localparam int STREAM_EDGES = 64;
`ifdef PHY_TX_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic       clk_4f   = 1'b0;
   logic       reset    = 1'b0;
   logic [7:0] data_in  = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic [7:0] sym_out;
   logic       sym_is_data;
   logic [1:0] link_state;

   int checks = 0;
   int errors = 0;

   phy_tx_symbol_gen #(
      .DATA_W       (8),
      .COM_SYM      (8'hBC),
      .IDLE_SYM     (8'h7C),
      .TRAIN_COMMAS (TC),
      .SKIP_PERIOD  (SP)
   ) dut (
      .clk_4f      (clk_4f),
      .reset       (reset),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .sym_out     (sym_out),
      .sym_is_data (sym_is_data),
      .link_state  (link_state)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns 1 when the k-th ACTIVE cycle (0-based) is a skip cycle.
   function automatic bit skip_at(input int k);
      return SKIP_EN && ((k % SP) == (SP - 1));
   endfunction

   // ---------------- behavioural model ----------------
   int         m_n     = 0;
   bit         m_valid = 1'b0;
   logic [7:0] e_sym;
   logic       e_dat;
   logic [1:0] e_link;
   logic       e_rdy;

   always @(posedge clk_4f) begin : model
      int n;
      int a;
      bit sk;
      if (!reset) begin
         m_n     <= 0;
         e_sym   <= 8'hBC;
         e_dat   <= 1'b0;
         e_link  <= 2'b01;
         e_rdy   <= 1'b0;
         m_valid <= 1'b1;
      end else begin
         n = m_n + 1;
         m_n <= n;
         if (n <= TC) begin
            e_sym  <= 8'hBC;
            e_dat  <= 1'b0;
            e_link <= (n == TC) ? 2'b10 : 2'b01;
            e_rdy  <= (n == TC) && !skip_at(0);
         end else begin
            a  = n - TC - 1;
            sk = skip_at(a);
            if (valid_in && !sk) begin
               e_sym <= data_in;
               e_dat <= 1'b1;
            end else if (sk) begin
               e_sym <= 8'hBC;
               e_dat <= 1'b0;
            end else begin
               e_sym <= 8'h7C;
               e_dat <= 1'b0;
            end
            e_link <= 2'b10;
            e_rdy  <= !skip_at(a + 1);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_4f) begin
      if (m_valid) begin
         chk("model_sym_out", 32'(sym_out), 32'(e_sym));
         chk("model_sym_is_data", 32'(sym_is_data), 32'(e_dat));
         chk("model_link_state", 32'(link_state), 32'(e_link));
         chk("model_ready_out", 32'(ready_out), 32'(e_rdy));
         if (sym_is_data === 1'b1) begin
            $display("tx byte 0x%02h link=%0b t=%0t", sym_out, link_state, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_4f);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      logic [7:0] d;
      logic [7:0] last;
      bit         acc;
      int         commas;
      int         rdy_low;
      int         sent;
      int         exp_commas;

      // Reset held for 3 edges.
      repeat (3) tick();
      chk("reset_sym_out", 32'(sym_out), 32'h0BC);
      chk("reset_sym_is_data", 32'(sym_is_data), 32'h0);
      chk("reset_link_state", 32'(link_state), 32'h1);
      chk("reset_ready_out", 32'(ready_out), 32'h0);

      // Release with valid_in=0. Commas through edge 4, then ACTIVE.
      reset = 1'b1;
      for (int i = 1; i <= TC; i++) begin
         tick();
         chk("train_sym_out", 32'(sym_out), 32'h0BC);
         chk("train_link_state", 32'(link_state), (i == TC) ? 32'h2 : 32'h1);
         chk("train_ready_out", 32'(ready_out), (i == TC) ? 32'h1 : 32'h0);
      end
      tick();
      chk("first_idle_sym", 32'(sym_out), 32'h07C);
      chk("first_idle_is_data", 32'(sym_is_data), 32'h0);

      // Burst of three bytes, then idle.
      valid_in = 1'b1;
      data_in  = 8'h11; tick();
      chk("burst_0x11", 32'(sym_out), 32'h011);
      chk("burst_0x11_is_data", 32'(sym_is_data), 32'h1);
      data_in  = 8'h22; tick();
      chk("burst_0x22", 32'(sym_out), 32'h022);
      data_in  = 8'h33; tick();
      chk("burst_0x33", 32'(sym_out), 32'h033);
      valid_in = 1'b0; tick();
      chk("burst_idle_sym", 32'(sym_out), 32'h07C);
      chk("burst_idle_is_data", 32'(sym_is_data), 32'h0);

      // Payloads that equal the comma and idle codes are not escaped.
      valid_in = 1'b1;
      data_in  = 8'hBC; tick();
      chk("payload_bc_sym", 32'(sym_out), 32'h0BC);
      chk("payload_bc_is_data", 32'(sym_is_data), 32'h1);
      chk("payload_bc_link", 32'(link_state), 32'h2);
      data_in  = 8'h7C; tick();
      chk("payload_7c_sym", 32'(sym_out), 32'h07C);
      chk("payload_7c_is_data", 32'(sym_is_data), 32'h1);
      valid_in = 1'b0; tick();
      chk("post_payload_idle", 32'(sym_out), 32'h07C);

      // Reset asserted mid-burst. 0x55 must never be sent.
      valid_in = 1'b1;
      data_in  = 8'h44; tick();
      chk("preburst_0x44", 32'(sym_out), 32'h044);
      data_in  = 8'h55;
      reset    = 1'b0; tick();
      chk("midreset_sym_out", 32'(sym_out), 32'h0BC);
      chk("midreset_is_data", 32'(sym_is_data), 32'h0);
      chk("midreset_ready", 32'(ready_out), 32'h0);
      chk("midreset_link", 32'(link_state), 32'h1);
      reset = 1'b1;
      for (int i = 1; i <= TC; i++) begin
         tick();
         chk("retrain_sym_out", 32'(sym_out), 32'h0BC);
         chk("retrain_is_data", 32'(sym_is_data), 32'h0);
         chk("retrain_link", 32'(link_state), (i == TC) ? 32'h2 : 32'h1);
         chk("retrain_ready", 32'(ready_out), (i == TC) ? 32'h1 : 32'h0);
      end

      // Continuous stream of incrementing bytes for 64 ACTIVE edges.
      d       = 8'h01;
      last    = 8'h00;
      commas  = 0;
      rdy_low = 0;
      sent    = 0;
      valid_in = 1'b1;
      for (int i = 0; i < STREAM_EDGES; i++) begin
         data_in = d;
         acc = (ready_out === 1'b1);
         if (!acc) rdy_low++;
         tick();
         if (acc) d = d + 8'd1;
         if (sym_is_data === 1'b1) begin
            chk("stream_sequence", 32'(sym_out), 32'(last + 8'd1));
            last = sym_out;
            sent++;
         end else if (sym_out === 8'hBC) begin
            commas++;
         end
      end
      valid_in = 1'b0;
      exp_commas = SKIP_EN ? (STREAM_EDGES / SP) : 0;
      chk("stream_commas", 32'(commas), 32'(exp_commas));
      chk("stream_ready_low", 32'(rdy_low), 32'(exp_commas));
      chk("stream_bytes_sent", 32'(sent), 32'(STREAM_EDGES - exp_commas));
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
